// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the 64x16 data RAM: CPU (port 0) and host loader (port 1).
// Define RAM_ARB_ROUND_ROBIN_EN for alternating tie-break instead of fixed CPU priority.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              grant_host_c;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On a tie the port that did not complete the previous access wins.
  assign grant_host_c = host_req && (!cpu_req || !last_owner_q);
`else
  assign grant_host_c = host_req && !cpu_req;
`endif

  always_ff @(posedge clk_main) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      owner_q      <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Outputs are computed one state ahead so each lands registered in its own state.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    owner_d      = owner_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req || host_req) begin
          state_d     = ACCESS;
          busy_d      = 1'b1;
          owner_d     = grant_host_c;
          ram_addr_d  = grant_host_c ? host_addr : cpu_addr;
          ram_wdata_d = grant_host_c ? host_wdata : cpu_wdata;
          ram_we_d    = grant_host_c ? host_we : cpu_we;
          ram_re_d    = grant_host_c ? !host_we : !cpu_we;
        end
      end
      ACCESS: begin
        state_d    = DONE;
        cpu_ack_d  = !owner_q;
        host_ack_d = owner_q;
        // RAM data is valid at the edge closing the read cycle.
        if (ram_re_q) begin
          if (owner_q) host_rdata_d = ram_rdata;
          else         cpu_rdata_d  = ram_rdata;
        end
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_owner_d = owner_q;
`endif
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign ram_re     = ram_re_q;
  assign owner      = owner_q;
  assign busy       = busy_q;

endmodule
